// File: rtl/instruction_queue.sv
// Instruction queue between the fetch unit and the decoder.
// Each 64-bit fetch block is split into 32-bit instructions with their PCs
// and stored in a circular buffer that the decoder drains from the head.
module instruction_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid,
    input  logic [63:0]              fetch_addr,
    input  logic [63:0]              fetch_data,
    output logic                     fetch_ready,
    input  logic                     flush,
    output logic                     dec_valid,
    output logic [63:0]              dec_pc,
    output logic [31:0]              dec_instr,
    input  logic                     dec_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     align_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [63:0]      pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] tail_nx;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] push_n;
    logic             align_err_q, align_err_d;
    logic             fetch_fire;
    logic             wr_pair;
    logic             wr_upper;
    logic             wr_bad;
    logic             pop;
    logic [63:0]      pc_upper;

    // Ready needs room for a full two-entry block; depends on registered count only
    assign fetch_ready = (count_q <= CNT_W'(DEPTH - 2));
    assign dec_valid   = (count_q != '0);
    assign dec_pc      = pc_q[head_q];
    assign dec_instr   = instr_q[head_q];
    assign count       = count_q;
    assign align_err   = align_err_q;

    // Decode push/pop and compute next pointer, count and error state
    always_comb begin
        fetch_fire  = fetch_valid && fetch_ready && !flush;
        wr_pair     = fetch_fire && (fetch_addr[2:0] == 3'b000);
        wr_upper    = fetch_fire && (fetch_addr[2:0] == 3'b100);
        wr_bad      = fetch_fire && (fetch_addr[1:0] != 2'b00);
        pop         = dec_valid && dec_ready && !flush;
        pc_upper    = fetch_addr + 64'd4;
        tail_nx     = tail_q + PTR_W'(1);
        push_n      = wr_pair ? CNT_W'(2) : (wr_upper ? CNT_W'(1) : CNT_W'(0));
        count_d     = count_q + push_n - CNT_W'(pop);
        tail_d      = tail_q + PTR_W'(push_n);
        head_d      = head_q + PTR_W'(pop);
        align_err_d = align_err_q | wr_bad;
        if (flush) begin
            count_d     = '0;
            tail_d      = '0;
            head_d      = '0;
            align_err_d = 1'b0;
        end
    end

    // Pointer, count and sticky error registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            align_err_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            align_err_q <= align_err_d;
        end
    end

    // Entry storage; cleared on reset so the empty head reads as zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (wr_pair) begin
            pc_q[tail_q]     <= fetch_addr;
            instr_q[tail_q]  <= fetch_data[31:0];
            pc_q[tail_nx]    <= pc_upper;
            instr_q[tail_nx] <= fetch_data[63:32];
        end else if (wr_upper) begin
            pc_q[tail_q]     <= fetch_addr;
            instr_q[tail_q]  <= fetch_data[63:32];
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue (DEPTH = 8).
module tb_instruction_queue;

    logic        clk;
    logic        reset;
    logic        fetch_valid;
    logic [63:0] fetch_addr;
    logic [63:0] fetch_data;
    logic        fetch_ready;
    logic        flush;
    logic        dec_valid;
    logic [63:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_ready;
    logic [3:0]  count;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    instruction_queue #(.DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_valid(fetch_valid),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .fetch_ready(fetch_ready),
        .flush      (flush),
        .dec_valid  (dec_valid),
        .dec_pc     (dec_pc),
        .dec_instr  (dec_instr),
        .dec_ready  (dec_ready),
        .count      (count),
        .align_err  (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before driving/sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] d);
        fetch_valid = 1'b1;
        fetch_addr  = a;
        fetch_data  = d;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic pop_one();
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [63:0] pc, input logic [31:0] ins);
        chk({tag, "_pc"}, dec_pc, pc);
        chk({tag, "_instr"}, 64'(dec_instr), 64'(ins));
    endtask

    initial begin
        reset       = 1'b0;
        fetch_valid = 1'b0;
        fetch_addr  = '0;
        fetch_data  = '0;
        flush       = 1'b0;
        dec_ready   = 1'b0;

        // Reset state
        #3;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("rst_dec_pc", dec_pc, 64'd0);
        chk("rst_dec_instr", 64'(dec_instr), 64'd0);
        chk("rst_align_err", 64'(align_err), 64'd0);
        chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        tick();
        tick();
        reset = 1'b1;

        // Aligned push splits into two entries
        push(64'h1000, 64'hBBBBBBBB_AAAAAAAA);
        chk("a8_valid", 64'(dec_valid), 64'd1);
        chk("a8_count", 64'(count), 64'd2);
        chk_head("a8_first", 64'h1000, 32'hAAAAAAAA);
        pop_one();
        chk("a8_pop_count", 64'(count), 64'd1);
        chk_head("a8_second", 64'h1004, 32'hBBBBBBBB);
        pop_one();
        chk("a8_empty_valid", 64'(dec_valid), 64'd0);

        // Upper-word-only push
        push(64'h2004, 64'h11111111_22222222);
        chk("a4_count", 64'(count), 64'd1);
        chk_head("a4", 64'h2004, 32'h11111111);
        pop_one();
        chk("a4_empty", 64'(count), 64'd0);

        // Fill to DEPTH; head=tail=3 now so the fill wraps
        for (int k = 0; k < 4; k++)
            push(64'h4000 + 64'(k * 8), {32'hB0000000 + 32'(k), 32'hA0000000 + 32'(k)});
        chk("full_count", 64'(count), 64'd8);
        chk("full_ready", 64'(fetch_ready), 64'd0);
        chk_head("full_head", 64'h4000, 32'hA0000000);
        fetch_valid = 1'b1;
        fetch_addr  = 64'h5000;
        fetch_data  = 64'h55555555_55555555;
        tick();
        chk("held_count", 64'(count), 64'd8);
        pop_one();
        chk("pop1_count", 64'(count), 64'd7);
        chk("pop1_ready", 64'(fetch_ready), 64'd0);
        pop_one();
        fetch_valid = 1'b0;
        chk("pop2_count", 64'(count), 64'd6);
        chk("pop2_ready", 64'(fetch_ready), 64'd1);
        chk_head("pop2_head", 64'h4008, 32'hA0000001);

        // Simultaneous push of two and pop of one at count 5
        pop_one();
        chk("c5_count", 64'(count), 64'd5);
        fetch_valid = 1'b1;
        fetch_addr  = 64'h6000;
        fetch_data  = 64'h66666666_55555555;
        dec_ready   = 1'b1;
        tick();
        fetch_valid = 1'b0;
        dec_ready   = 1'b0;
        chk("pp_count", 64'(count), 64'd6);
        chk_head("drain0", 64'h4010, 32'hA0000002);
        pop_one();
        chk_head("drain1", 64'h4014, 32'hB0000002);
        pop_one();
        chk_head("drain2", 64'h4018, 32'hA0000003);
        pop_one();
        chk_head("drain3", 64'h401C, 32'hB0000003);
        pop_one();
        chk_head("drain4", 64'h6000, 32'h55555555);
        pop_one();
        chk_head("drain5", 64'h6004, 32'h66666666);
        pop_one();
        chk("drained_count", 64'(count), 64'd0);

        // Flush beats a same-cycle fetch and pop
        push(64'h7000, 64'h70000001_70000000);
        push(64'h7008, 64'h70000003_70000002);
        push(64'h7010, 64'h70000005_70000004);
        chk("pre_flush_count", 64'(count), 64'd6);
        fetch_valid = 1'b1;
        fetch_addr  = 64'h8000;
        fetch_data  = 64'h80000001_80000000;
        dec_ready   = 1'b1;
        flush       = 1'b1;
        tick();
        fetch_valid = 1'b0;
        dec_ready   = 1'b0;
        flush       = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(dec_valid), 64'd0);
        tick();
        chk("flush_later_count", 64'(count), 64'd0);
        push(64'h9000, 64'h90000001_90000000);
        chk("post_flush_count", 64'(count), 64'd2);
        chk_head("post_flush", 64'h9000, 32'h90000000);

        // Misaligned fetch: no write, sticky error until flush
        push(64'h3002, 64'hDEADBEEF_DEADBEEF);
        chk("mis_count", 64'(count), 64'd2);
        chk("mis_err", 64'(align_err), 64'd1);
        tick();
        chk("mis_err_held", 64'(align_err), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("mis_err_cleared", 64'(align_err), 64'd0);
        chk("mis_flush_count", 64'(count), 64'd0);

        // PC wraps modulo 2^64
        push(64'hFFFFFFFF_FFFFFFF8, 64'hDDDDDDDD_CCCCCCCC);
        chk_head("wrap_lo", 64'hFFFFFFFF_FFFFFFF8, 32'hCCCCCCCC);
        pop_one();
        chk_head("wrap_hi", 64'hFFFFFFFF_FFFFFFFC, 32'hDDDDDDDD);
        pop_one();

        // Asynchronous reset mid-fill
        push(64'hA000, 64'hA0000001_A0000000);
        push(64'hA008, 64'hA0000003_A0000002);
        chk("prerst_count", 64'(count), 64'd4);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_valid", 64'(dec_valid), 64'd0);
        chk("async_rst_pc", dec_pc, 64'd0);
        chk("async_rst_ready", 64'(fetch_ready), 64'd1);
        #1;
        reset = 1'b1;
        tick();
        push(64'hB004, 64'hB0000001_B0000000);
        chk("after_rst_count", 64'(count), 64'd1);
        chk_head("after_rst", 64'hB004, 32'hB0000001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 Parameter: DEPTH, 8, number of 32-bit instruction entries; power of two, minimum 4.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset (reset=0 resets).
REQ-004 Port: fetch_valid  in  1  fetcher has completed a fetch; fetch_addr/fetch_data are valid.
REQ-005 Port: fetch_addr  in  64  byte address used for the fetch.
REQ-006 Port: fetch_data  in  64  little-endian 8-byte block fetched at fetch_addr.
REQ-007 Port: fetch_ready  out  1  queue can accept one fetch this cycle.
REQ-008 Port: flush  in  1  redirect (branch/jump); discard all queued and incoming instructions.
REQ-009 Port: dec_valid  out  1  head entry presented to decoder.
REQ-010 Port: dec_pc  out  64  PC of head entry.
REQ-011 Port: dec_instr  out  32  instruction bits of head entry.
REQ-012 Port: dec_ready  in  1  decoder consumes head entry this cycle.
REQ-013 Port: count  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-014 Port: align_err  out  1  sticky flag: a fetch with fetch_addr[1:0]!=0 was accepted.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries {pc[63:0], instr[31:0]} with head/tail pointers wrapping modulo DEPTH.
REQ-016 fetch_ready SHALL equal (DEPTH - count) >= 2, decoded from registered count only, no combinational path from any input.
REQ-017 A push SHALL occur when fetch_valid && fetch_ready && !flush.
REQ-018 Push with fetch_addr[2:0]==0 SHALL write two entries: (fetch_addr, fetch_data[31:0]) at tail, then (fetch_addr+4, fetch_data[63:32]) at tail+1.
REQ-019 Push with fetch_addr[2:0]==4 SHALL write one entry: (fetch_addr, fetch_data[63:32]).
REQ-020 Push with fetch_addr[1:0]!=0 SHALL write nothing and set align_err on the next edge.
REQ-021 fetch_valid while fetch_ready=0 SHALL be ignored (no write, no error); the fetcher holds and retries.
REQ-022 A pop SHALL occur when dec_valid && dec_ready && !flush; head advances by one.
REQ-023 dec_valid SHALL equal (count != 0); dec_pc/dec_instr SHALL be driven from the head entry with no input bypass.
REQ-024 Latency: an entry pushed at edge N SHALL first appear on dec_* in the cycle after edge N.
REQ-025 Simultaneous push and pop SHALL both take effect; next count = count + pushed(0/1/2) - popped(0/1).
REQ-026 PC arithmetic SHALL be 64-bit modulo 2^64 (0xFFFF_FFFF_FFFF_FFF8 + 4 wraps to upper-word PC 0xFFFF_FFFF_FFFF_FFFC, no carry-out).
REQ-027 flush SHALL have priority over push and pop: at the next edge count, head, tail <= 0; align_err <= 0; storage contents need not be cleared.
REQ-028 dec_valid SHALL be 0 in the cycle following a flush edge regardless of same-cycle fetch_valid.
REQ-029 count SHALL never exceed DEPTH nor underflow; pop with count==0 is impossible by REQ-022/023.

Reset
REQ-030 While reset=0, asynchronously: count=0, head=tail=0, dec_valid=0, dec_pc=0, dec_instr=0, align_err=0, fetch_ready=1.
REQ-031 All storage entries SHALL reset to zero so dec_pc/dec_instr are deterministic when empty.
REQ-032 Reset asserted mid-operation SHALL discard all entries immediately; first push after release behaves as from empty.

Verification
REQ-033 Reset, push addr=0x1000 data=0xBBBBBBBB_AAAAAAAA, dec_ready=0 -> next cycle dec_valid=1, dec_pc=0x1000, dec_instr=0xAAAAAAAA, count=2; pop -> dec_pc=0x1004, dec_instr=0xBBBBBBBB.
REQ-034 Push addr=0x2004 data=0x11111111_22222222 -> one entry, dec_pc=0x2004, dec_instr=0x11111111, count=1.
REQ-035 DEPTH=8, dec_ready=0, four aligned pushes -> count=8, fetch_ready=0; fifth fetch_valid held -> no change; single pop -> count=7, fetch_ready=0; second pop -> count=6, fetch_ready=1.
REQ-036 count=5, push 2 and pop 1 same cycle -> count=6, dec order preserved across pointer wrap.
REQ-037 count=6 with fetch_valid=1, dec_ready=1, flush=1 -> next cycle count=0, dec_valid=0, nothing from that fetch appears later.
REQ-038 Push addr=0x3002 -> count unchanged, align_err=1 next cycle and held until flush; reset=0 mid-fill -> count=0, dec_valid=0 immediately, before next clk edge.
